// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg -- shared definitions for the grant-hold arbiter front end.
//
// Contents:
//   arb_state_e    : lock FSM state (IDLE, LOCK)
//   MAX_WID        : widest request bus the bit helpers below support
//   lowest_set()   : isolates the lowest-index set bit of a vector
//   is_multi_hot() : true when more than one bit of a vector is set
// ---------------------------------------------------------------------------
package arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

   // Callers zero-extend their bus into this width and truncate the result.
   localparam int MAX_WID = 64;

   // Two's-complement trick: v & -v leaves only the lowest set bit.
   function automatic logic [MAX_WID-1:0] lowest_set(input logic [MAX_WID-1:0] v);
      return v & (~v + MAX_WID'(1));
   endfunction

   // Clearing the lowest set bit leaves something only if another bit was set.
   function automatic logic is_multi_hot(input logic [MAX_WID-1:0] v);
      return |(v & (v - MAX_WID'(1)));
   endfunction

endpackage

// File: rtl/arb_grant_hold_if.sv
// ---------------------------------------------------------------------------
// arb_grant_hold_if -- request/grant/ownership bundle of arb_grant_hold.
//
// Signals (all WID bits unless noted):
//   rqsts     : live request bus (also seen by the upstream arbiter)
//   grnts     : upstream arbiter grant, one-hot or zero
//   done      : per-requester end-of-transaction strobe
//   grnt_hold : registered one-hot owner
//   arb_en    : 1 bit, upstream arbiter may advance
//   busy      : 1 bit, an owner is locked
//   multi_err : 1 bit, pulse after a multi-hot grant was sampled
//   to_err    : 1 bit, pulse after a lock timed out
//
// Protocol: grnts is only looked at while arb_en is high. A sampled nonzero
// grant makes its lowest set bit the owner on grnt_hold from the next cycle;
// ownership ends when the owner strobes its done bit or drops its request,
// and grnt_hold returns to zero for at least one cycle before a new owner.
//
// Modports: slave = arb_grant_hold view, master = requester/arbiter side.
// ---------------------------------------------------------------------------
interface arb_grant_hold_if #(
   parameter int WID = 16
);
   logic [WID-1:0] rqsts;
   logic [WID-1:0] grnts;
   logic [WID-1:0] done;
   logic [WID-1:0] grnt_hold;
   logic           arb_en;
   logic           busy;
   logic           multi_err;
   logic           to_err;

   modport slave (
      input  rqsts, grnts, done,
      output grnt_hold, arb_en, busy, multi_err, to_err
   );

   modport master (
      output rqsts, grnts, done,
      input  grnt_hold, arb_en, busy, multi_err, to_err
   );
endinterface

// File: rtl/arb_grant_hold_cnt.sv
// ---------------------------------------------------------------------------
// arb_grant_hold_cnt -- lock-duration counter, saturating at TO_LIM.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   clr    : synchronous clear (held while the owner FSM is idle)
//   en     : count this cycle (owner FSM is locked)
//   at_lim : high during the lock cycle that is the TO_LIM-th one, i.e. the
//            cycle whose count update brings the counter to TO_LIM
// ---------------------------------------------------------------------------
module arb_grant_hold_cnt #(
   parameter int TO_LIM = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic at_lim
);

   localparam int            CW     = $clog2(TO_LIM + 1);
   localparam logic [CW-1:0] LIM    = CW'(TO_LIM);
   localparam logic [CW-1:0] LIM_M1 = CW'(TO_LIM - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en && (cnt_q != LIM)) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   // The counter holds (k-1) during the k-th lock cycle, so the limit cycle
   // is flagged one count early; a lock of TO_LIM cycles then releases on time.
   assign at_lim = en && (cnt_q == LIM_M1);

endmodule

// File: rtl/arb_grant_hold.sv
// ---------------------------------------------------------------------------
// arb_grant_hold -- locks the upstream round-robin grant onto one owner until
// that owner finishes (done) or abandons (request dropped).
//
// Parameters:
//   WID    : request/grant bus width (at most arb_pkg::MAX_WID)
//   TO_LIM : maximum lock duration in cycles (1..65535)
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : arb_grant_hold_if.slave (rqsts, grnts, done in;
//           grnt_hold, arb_en, busy, multi_err, to_err out)
//
// Build option:
//   ARB_GRANT_HOLD_TIMEOUT_EN : when defined, a lock lasting TO_LIM cycles is
//   force-released with a to_err pulse; otherwise to_err is tied low and a
//   lock lasts until done or abandonment.
//
// busy/arb_en are a direct decode of the FSM state and serve as its debug view.
// ---------------------------------------------------------------------------
module arb_grant_hold
   import arb_pkg::*;
#(
   parameter int WID    = 16,
   parameter int TO_LIM = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   arb_grant_hold_if.slave   bus
);

   arb_state_e     state_q, state_d;
   logic [WID-1:0] hold_q, hold_d;
   logic           multi_q, multi_d;
   logic           to_q, to_d;
   logic           release_req;
   logic           at_lim;

   arb_grant_hold_cnt #(
      .TO_LIM (TO_LIM)
   ) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (state_q == IDLE),
      .en     (state_q == LOCK),
      .at_lim (at_lim)
   );

   // Only the owner's done/request bits matter; everyone else is masked off.
   assign release_req = (|(bus.done & hold_q)) || !(|(bus.rqsts & hold_q));

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      multi_d = 1'b0;
      to_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (|bus.grnts) begin
               state_d = LOCK;
               hold_d  = WID'(lowest_set(MAX_WID'(bus.grnts)));
               multi_d = is_multi_hot(MAX_WID'(bus.grnts));
            end else begin
               hold_d  = '0;
            end
         end
         LOCK: begin
            // Always passes through IDLE, so a new owner needs a fresh grant.
            if (release_req) begin
               state_d = IDLE;
               hold_d  = '0;
            end
`ifdef ARB_GRANT_HOLD_TIMEOUT_EN
            else if (at_lim) begin
               state_d = IDLE;
               hold_d  = '0;
               to_d    = 1'b1;
            end
`endif
         end
         default: begin
            state_d = IDLE;
            hold_d  = '0;
         end
      endcase
   end

`ifndef ARB_GRANT_HOLD_TIMEOUT_EN
   logic unused_at_lim;
   assign unused_at_lim = at_lim;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         hold_q  <= '0;
         multi_q <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         multi_q <= multi_d;
         to_q    <= to_d;
      end
   end

   assign bus.grnt_hold = hold_q;
   assign bus.arb_en    = (state_q == IDLE);
   assign bus.busy      = (state_q == LOCK);
   assign bus.multi_err = multi_q;
`ifdef ARB_GRANT_HOLD_TIMEOUT_EN
   assign bus.to_err    = to_q;
`else
   assign bus.to_err    = 1'b0;
   logic unused_to_q;
   assign unused_to_q = to_q;
`endif

endmodule
